// File: rtl/axi_master_mux.sv
// rtl/axi_master_mux.sv - routes one granted master to the shared AXI slave for a full transaction
module axi_master_mux #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_M-1:0]        gnt,
  input  logic [NUM_M*ADDR_W-1:0] m_awaddr,
  input  logic [NUM_M-1:0]        m_awvalid,
  output logic [NUM_M-1:0]        m_awready,
  input  logic [NUM_M*DATA_W-1:0] m_wdata,
  input  logic [NUM_M-1:0]        m_wvalid,
  input  logic [NUM_M-1:0]        m_wlast,
  output logic [NUM_M-1:0]        m_wready,
  output logic [1:0]              m_bresp,
  output logic [NUM_M-1:0]        m_bvalid,
  input  logic [NUM_M-1:0]        m_bready,
  input  logic [NUM_M*ADDR_W-1:0] m_araddr,
  input  logic [NUM_M-1:0]        m_arvalid,
  output logic [NUM_M-1:0]        m_arready,
  output logic [DATA_W-1:0]       m_rdata,
  output logic [1:0]              m_rresp,
  output logic                    m_rlast,
  output logic [NUM_M-1:0]        m_rvalid,
  input  logic [NUM_M-1:0]        m_rready,
  output logic [ADDR_W-1:0]       s_awaddr,
  output logic                    s_awvalid,
  input  logic                    s_awready,
  output logic [DATA_W-1:0]       s_wdata,
  output logic                    s_wvalid,
  output logic                    s_wlast,
  input  logic                    s_wready,
  input  logic [1:0]              s_bresp,
  input  logic                    s_bvalid,
  output logic                    s_bready,
  output logic [ADDR_W-1:0]       s_araddr,
  output logic                    s_arvalid,
  input  logic                    s_arready,
  input  logic [DATA_W-1:0]       s_rdata,
  input  logic [1:0]              s_rresp,
  input  logic                    s_rlast,
  input  logic                    s_rvalid,
  output logic                    s_rready,
  output logic                    busy,
  output logic                    txn_done,
  output logic [1:0]              txn_resp
);

  localparam int SEL_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt, w_gnt_idx;
  logic             r_txn_done, w_done_nxt;
  logic [1:0]       r_txn_resp, w_resp_nxt;

  // Multi-hot grants are resolved to the lowest index: scan downward so the last hit wins.
  always_comb begin
    w_gnt_idx = '0;
    for (int i = NUM_M-1; i >= 0; i--) begin
      if (gnt[i]) w_gnt_idx = SEL_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_txn_done <= 1'b0;
      r_txn_resp <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_txn_done <= w_done_nxt;
      r_txn_resp <= w_resp_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_done_nxt  = 1'b0;
    w_resp_nxt  = r_txn_resp;
    s_awvalid   = 1'b0;
    s_wvalid    = 1'b0;
    s_bready    = 1'b0;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    m_awready   = '0;
    m_wready    = '0;
    m_bvalid    = '0;
    m_arready   = '0;
    m_rvalid    = '0;
    case (r_state)
      S_IDLE: begin
        if (gnt != '0) begin
          if (m_awvalid[w_gnt_idx]) begin
            w_sel_nxt   = w_gnt_idx;
            w_state_nxt = S_AW;
          end else if (m_arvalid[w_gnt_idx]) begin
            w_sel_nxt   = w_gnt_idx;
            w_state_nxt = S_AR;
          end
        end
      end
      S_AW: begin
        s_awvalid        = m_awvalid[r_sel];
        m_awready[r_sel] = s_awready;
        if (s_awvalid && s_awready) w_state_nxt = S_W;
      end
      S_W: begin
        s_wvalid        = m_wvalid[r_sel];
        m_wready[r_sel] = s_wready;
        if (s_wvalid && s_wready && s_wlast) w_state_nxt = S_B;
      end
      S_B: begin
        m_bvalid[r_sel] = s_bvalid;
        s_bready        = m_bready[r_sel];
        if (s_bvalid && s_bready) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_resp_nxt  = s_bresp;
        end
      end
      S_AR: begin
        s_arvalid        = m_arvalid[r_sel];
        m_arready[r_sel] = s_arready;
        if (s_arvalid && s_arready) w_state_nxt = S_R;
      end
      S_R: begin
        m_rvalid[r_sel] = s_rvalid;
        s_rready        = m_rready[r_sel];
        if (s_rvalid && s_rready && s_rlast) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_resp_nxt  = s_rresp;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Payloads follow the latched master unconditionally; only valid/ready are gated by state.
  assign s_awaddr = m_awaddr[r_sel*ADDR_W +: ADDR_W];
  assign s_araddr = m_araddr[r_sel*ADDR_W +: ADDR_W];
  assign s_wdata  = m_wdata[r_sel*DATA_W +: DATA_W];
  assign s_wlast  = m_wlast[r_sel];
  assign m_bresp  = s_bresp;
  assign m_rdata  = s_rdata;
  assign m_rresp  = s_rresp;
  assign m_rlast  = s_rlast;
  assign busy     = (r_state != S_IDLE);
  assign txn_done = r_txn_done;
  assign txn_resp = r_txn_resp;

endmodule

// File: tb/tb_axi_master_mux.sv
// tb/tb_axi_master_mux.sv - randomized scoreboard bench for axi_master_mux
module tb_axi_master_mux;
  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NM-1:0] gnt;
  logic [NM*AW-1:0] m_awaddr, m_araddr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM-1:0] m_awvalid, m_awready, m_wvalid, m_wlast, m_wready;
  logic [NM-1:0] m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0] m_bresp, m_rresp, s_bresp, s_rresp, txn_resp;
  logic [DW-1:0] m_rdata, s_wdata, s_rdata;
  logic m_rlast;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rlast, s_rvalid, s_rready, busy, txn_done;

  int n_checks = 0;
  int n_fail   = 0;

  axi_master_mux #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .gnt(gnt),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .busy(busy), .txn_done(txn_done), .txn_resp(txn_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    gnt = '0; m_awaddr = '0; m_araddr = '0; m_wdata = '0;
    m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0; m_arvalid = '0; m_rready = '0;
    s_awready = 0; s_wready = 0; s_bresp = 0; s_bvalid = 0; s_arready = 0;
    s_rdata = '0; s_rresp = 0; s_rlast = 0; s_rvalid = 0;
  endtask

  // Transaction-level scoreboard: tracks address accepted, beats moved and response handshake,
  // and derives every expected routing value from those counts plus the bench's own stimulus.
  task automatic run_txn(input int m, input bit rd, input int nb, input logic [1:0] resp,
                         input logic [NM-1:0] g, input bit tie, input bit abort);
    logic [DW-1:0] q[$];
    logic [AW-1:0] addr;
    int o = 1 - m;
    int beats = 0;
    int cyc = 0;
    bit a_done = 0, hs_prev = 0, fin = 0;
    bit in_w, in_b, in_r;
    addr = $urandom;
    for (int i = 0; i < nb; i++) q.push_back($urandom);
    @(negedge clk);
    gnt = g;
    if (rd) begin m_arvalid[m] = 1; m_araddr[m*AW +: AW] = addr; end
    else begin m_awvalid[m] = 1; m_awaddr[m*AW +: AW] = addr; m_arvalid[m] = tie; end
    #1;
    check("idle_busy", busy, 0);
    check("idle_done", txn_done, 0);
    check("lat_awvalid", s_awvalid, 0);
    check("lat_arvalid", s_arvalid, 0);
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (abort && !rd && beats == nb && !hs_prev) begin
        s_bvalid = 1; m_bready[m] = 1;
        #1 check("abort_pre_bvalid", m_bvalid[m], 1);
        rst = 0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_bvalid", m_bvalid, 0);
        check("abort_bready", s_bready, 0);
        check("abort_done", txn_done, 0);
        clear_inputs();
        @(negedge clk);
        rst = 1;
        #1;
        check("abort_done_after", txn_done, 0);
        check("abort_busy_after", busy, 0);
        fin = 1;
      end else if (hs_prev || cyc > 300) begin
        clear_inputs();
        #1;
        check("txn_done", txn_done, 1);
        check("txn_resp", txn_resp, resp);
        check("busy_end", busy, 0);
        fin = 1;
      end else begin
        in_w = !rd && a_done && beats < nb;
        in_b = !rd && beats == nb;
        in_r = rd && a_done && beats < nb;
        gnt = NM'($urandom);
        m_awvalid[o] = 1'($urandom); m_wvalid[o] = 1'($urandom); m_arvalid[o] = 1'($urandom);
        m_bready[o]  = 1'($urandom); m_rready[o] = 1'($urandom);
        m_awvalid[m] = !rd && !a_done;
        m_arvalid[m] = rd ? !a_done : tie;
        m_wvalid[m]  = in_w && 1'($urandom);
        m_wdata[m*DW +: DW] = (beats < nb) ? q[beats] : DW'($urandom);
        m_wlast[m]   = (beats == nb - 1);
        m_bready[m]  = 1'($urandom);
        m_rready[m]  = 1'($urandom);
        s_awready = 1'($urandom); s_arready = 1'($urandom); s_wready = 1'($urandom);
        s_bvalid  = 1'($urandom); s_rvalid  = 1'($urandom); s_bresp = resp;
        s_rdata   = $urandom;
        s_rlast   = in_r ? (beats == nb - 1) : 1'($urandom);
        s_rresp   = (in_r && beats == nb - 1) ? resp : 2'($urandom);
        #1;
        check("busy", busy, 1);
        check("done_mid", txn_done, 0);
        check("iso_other", {m_awready[o], m_wready[o], m_bvalid[o], m_arready[o], m_rvalid[o]}, 0);
        check("s_awvalid", s_awvalid, !rd && !a_done);
        check("s_arvalid", s_arvalid, rd && !a_done);
        check("m_awready", m_awready[m], !rd && !a_done && s_awready);
        check("m_arready", m_arready[m], rd && !a_done && s_arready);
        check("s_wvalid", s_wvalid, in_w && m_wvalid[m]);
        check("m_wready", m_wready[m], in_w && s_wready);
        check("m_bvalid", m_bvalid[m], in_b && s_bvalid);
        check("s_bready", s_bready, in_b && m_bready[m]);
        check("m_rvalid", m_rvalid[m], in_r && s_rvalid);
        check("s_rready", s_rready, in_r && m_rready[m]);
        check("m_bresp", m_bresp, s_bresp);
        if (!a_done && !rd && s_awvalid && s_awready) begin
          check("awaddr", s_awaddr, addr); a_done = 1;
        end
        if (!a_done && rd && s_arvalid && s_arready) begin
          check("araddr", s_araddr, addr); a_done = 1;
        end
        if (in_w && s_wvalid && s_wready) begin
          check("wdata", s_wdata, q[beats]);
          check("wlast", s_wlast, beats == nb - 1);
          beats++;
        end
        if (in_b && s_bvalid && s_bready) hs_prev = 1;
        if (in_r && s_rvalid && s_rready) begin
          check("rdata", m_rdata, s_rdata);
          check("rlast", m_rlast, beats == nb - 1);
          beats++;
          if (beats == nb) hs_prev = 1;
        end
      end
    end
    if (!abort) check("beats", beats, nb);
  endtask

  initial begin
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_svalid", {s_awvalid, s_wvalid, s_arvalid}, 0);
    check("rst_sready", {s_bready, s_rready}, 0);
    check("rst_mready", {m_awready, m_wready, m_arready}, 0);
    check("rst_mvalid", {m_bvalid, m_rvalid}, 0);
    check("rst_done", txn_done, 0);
    @(negedge clk);
    gnt = 2'b01;
    repeat (3) @(negedge clk);
    #1 check("gnt_novalid_busy", busy, 0);
    clear_inputs();
    run_txn(0, 0, 1, 2'b00, 2'b01, 0, 0);
    run_txn(1, 1, 4, 2'b10, 2'b10, 0, 0);
    run_txn(0, 0, 3, 2'b01, 2'b01, 1, 0);
    run_txn(0, 1, 2, 2'b11, 2'b11, 0, 0);
    run_txn(0, 0, 2, 2'b00, 2'b01, 0, 1);
    run_txn(0, 0, 1, 2'b00, 2'b01, 0, 0);
    for (int t = 0; t < 24; t++) begin
      automatic int mm = $urandom_range(0, 1);
      run_txn(mm, 1'($urandom), $urandom_range(1, 6), 2'($urandom), NM'(1 << mm), 1'($urandom), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
